// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared decode/execute bundle types and constants
package pipe_pkg;

    localparam int DATA_W_C = 32;
    localparam int REG_AW_C = 4;
    localparam int CTRL_W_C = 8;

    // Default-width decode-to-execute payload; field order is ctrl, WA3, RD1, RD2, immExt.
    typedef struct packed {
        logic [CTRL_W_C-1:0] ctrl;
        logic [REG_AW_C-1:0] wa3;
        logic [DATA_W_C-1:0] rd1;
        logic [DATA_W_C-1:0] rd2;
        logic [DATA_W_C-1:0] imm_ext;
    } dec_exe_bundle_t;

    localparam int              BUNDLE_W_C = $bits(dec_exe_bundle_t);
    localparam dec_exe_bundle_t DE_BUBBLE  = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with synchronous clear
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise step by one and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_dec_exe_stage.sv
// rtl/pipe_dec_exe_stage.sv - D->E pipeline register with handshake, flush, stall counter; optional skid slot via PIPE_DE_SKID_EN
module pipe_dec_exe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_C,
    parameter int REG_AW = REG_AW_C,
    parameter int CTRL_W = CTRL_W_C,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    output logic              ready_d,
    input  logic [DATA_W-1:0] immExtD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic              flush,
    output logic              valid_e,
    input  logic              ready_e,
    output logic [DATA_W-1:0] immExtE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [REG_AW-1:0] WA3E,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Same layout as dec_exe_bundle_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] wa3;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm_ext;
    } bundle_t;

    localparam bundle_t BUBBLE = '0;

    bundle_t in_w;
    bundle_t main_q;
    bundle_t main_d;
    logic    valid_e_q;
    logic    valid_e_d;
    logic    accept;
    logic    stall_inc;

    assign in_w.ctrl    = ctrlD;
    assign in_w.wa3     = WA3D;
    assign in_w.rd1     = RD1D;
    assign in_w.rd2     = RD2D;
    assign in_w.imm_ext = immExtD;

    assign accept = valid_d & ready_d;

`ifdef PIPE_DE_SKID_EN

    bundle_t skid_q;
    bundle_t skid_d;
    logic    skid_valid_q;
    logic    skid_valid_d;

    // Registered ready: decode may push while the skid slot is empty, even during a stall.
    assign ready_d = !skid_valid_q;

    // Next state for main and skid slots; the skid entry always leaves before a newer one.
    always_comb begin
        main_d       = main_q;
        valid_e_d    = valid_e_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            valid_e_d    = 1'b0;
            main_d.ctrl  = '0;
            skid_valid_d = 1'b0;
        end else if (!valid_e_q || ready_e) begin
            if (skid_valid_q) begin
                main_d    = skid_q;
                valid_e_d = 1'b1;
                if (accept) begin
                    skid_d       = in_w;
                    skid_valid_d = 1'b1;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                main_d    = in_w;
                valid_e_d = 1'b1;
            end else if (valid_e_q) begin
                valid_e_d   = 1'b0;
                main_d.ctrl = '0;
            end
        end else if (accept) begin
            skid_d       = in_w;
            skid_valid_d = 1'b1;
        end
    end

    // Skid slot register; contents only matter while skid_valid_q is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q       <= BUBBLE;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`else

    logic drain;

    assign drain   = valid_e_q & ready_e;
    // Accept whenever the register is empty or is being emptied this cycle.
    assign ready_d = !valid_e_q | ready_e;

    // Next state in priority order: flush, accept, drain-only bubble, hold.
    always_comb begin
        main_d    = main_q;
        valid_e_d = valid_e_q;
        if (flush) begin
            valid_e_d   = 1'b0;
            main_d.ctrl = '0;
        end else if (accept) begin
            main_d    = in_w;
            valid_e_d = 1'b1;
        end else if (drain) begin
            valid_e_d   = 1'b0;
            main_d.ctrl = '0;
        end
    end

`endif

    // Main execute-side register; data fields persist across bubbles, ctrl does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q    <= BUBBLE;
            valid_e_q <= 1'b0;
        end else begin
            main_q    <= main_d;
            valid_e_q <= valid_e_d;
        end
    end

    assign valid_e = valid_e_q;
    assign immExtE = main_q.imm_ext;
    assign RD1E    = main_q.rd1;
    assign RD2E    = main_q.rd2;
    assign WA3E    = main_q.wa3;
    assign ctrlE   = main_q.ctrl;

    // A flushed stall cycle is not charged to the counter.
    assign stall_inc = valid_e_q & ~ready_e & ~flush;

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_dec_exe_stage.sv
// tb/tb_pipe_dec_exe_stage.sv - directed table plus randomized model check for pipe_dec_exe_stage
module tb_pipe_dec_exe_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, valid_d, ready_e, flush;
    logic [31:0] immExtD, RD1D, RD2D;
    logic [3:0]  WA3D;
    logic [7:0]  ctrlD;
    logic        ready_d, valid_e;
    logic [31:0] immExtE, RD1E, RD2E;
    logic [3:0]  WA3E;
    logic [7:0]  ctrlE;
    logic [15:0] stall_cnt;
    logic        ready_d_s, valid_e_s;
    logic [31:0] immExtE_s, RD1E_s, RD2E_s;
    logic [3:0]  WA3E_s;
    logic [7:0]  ctrlE_s;
    logic [3:0]  stall_cnt_s;

    always #5 clk = ~clk;

    pipe_dec_exe_stage dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(ready_d),
        .immExtD(immExtD), .RD1D(RD1D), .RD2D(RD2D), .WA3D(WA3D), .ctrlD(ctrlD),
        .flush(flush), .valid_e(valid_e), .ready_e(ready_e),
        .immExtE(immExtE), .RD1E(RD1E), .RD2E(RD2E), .WA3E(WA3E), .ctrlE(ctrlE),
        .stall_cnt(stall_cnt)
    );

    pipe_dec_exe_stage #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(ready_d_s),
        .immExtD(immExtD), .RD1D(RD1D), .RD2D(RD2D), .WA3D(WA3D), .ctrlD(ctrlD),
        .flush(flush), .valid_e(valid_e_s), .ready_e(ready_e),
        .immExtE(immExtE_s), .RD1E(RD1E_s), .RD2E(RD2E_s), .WA3E(WA3E_s), .ctrlE(ctrlE_s),
        .stall_cnt(stall_cnt_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instructions in flight as a queue, plus last shown payload.
    dec_exe_bundle_t q[$];
    dec_exe_bundle_t shown = '0;
    int              cnt_m = 0;
    int              cnt_sm = 0;

    function automatic logic model_ready();
`ifdef PIPE_DE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || ready_e;
`endif
    endfunction

    task automatic drive(input logic r, input logic vd, input logic re, input logic fl,
                         input logic [31:0] imm, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [3:0] wa3, input logic [7:0] ctrl);
        rst = r; valid_d = vd; ready_e = re; flush = fl;
        immExtD = imm; RD1D = rd1; RD2D = rd2; WA3D = wa3; ctrlD = ctrl;
        #1;
    endtask

    task automatic advance();
        logic            rdy;
        int              sz;
        dec_exe_bundle_t b;
        rdy = model_ready();
        sz  = q.size();
        b.ctrl = ctrlD; b.wa3 = WA3D; b.rd1 = RD1D; b.rd2 = RD2D; b.imm_ext = immExtD;
        @(posedge clk);
        if (rst) begin
            q.delete();
            shown  = '0;
            cnt_m  = 0;
            cnt_sm = 0;
        end else begin
            if (sz > 0 && !ready_e && !flush) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt_sm < 15) cnt_sm++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (sz > 0 && ready_e) void'(q.pop_front());
                if (valid_d && rdy) q.push_back(b);
            end
            if (q.size() > 0) shown = q[0];
        end
        @(negedge clk);
    endtask

    task automatic check_model();
        logic       ve;
        logic [7:0] ce;
        ve = (q.size() > 0);
        ce = ve ? q[0].ctrl : 8'h00;
        chk("m.valid_e", valid_e, ve);
        chk("m.ready_d", ready_d, model_ready());
        chk("m.immExtE", immExtE, shown.imm_ext);
        chk("m.RD1E", RD1E, shown.rd1);
        chk("m.RD2E", RD2E, shown.rd2);
        chk("m.WA3E", WA3E, shown.wa3);
        chk("m.ctrlE", ctrlE, ce);
        chk("m.stall_cnt", stall_cnt, cnt_m);
        chk("m.stall_cnt_small", stall_cnt_s, cnt_sm);
    endtask

    typedef struct {
        logic        rst, vd, re, fl;
        logic [31:0] imm, rd1, rd2;
        logic [3:0]  wa3;
        logic [7:0]  ctrl;
        logic        e_ve, e_rdy;
        logic [31:0] e_imm, e_rd1, e_rd2;
        logic [3:0]  e_wa3;
        logic [7:0]  e_ctrl;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic vd, input logic re, input logic fl,
                                input logic [31:0] imm, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [3:0] wa3, input logic [7:0] ctrl,
                                input logic eve, input logic erdy, input logic [31:0] eimm,
                                input logic [31:0] erd1, input logic [31:0] erd2,
                                input logic [3:0] ewa3, input logic [7:0] ectrl, input logic [15:0] ecnt);
        vec_t v;
        v.rst = r; v.vd = vd; v.re = re; v.fl = fl;
        v.imm = imm; v.rd1 = rd1; v.rd2 = rd2; v.wa3 = wa3; v.ctrl = ctrl;
        v.e_ve = eve; v.e_rdy = erdy; v.e_imm = eimm; v.e_rd1 = erd1; v.e_rd2 = erd2;
        v.e_wa3 = ewa3; v.e_ctrl = ectrl; v.e_cnt = ecnt;
        return v;
    endfunction

    initial begin
`ifdef PIPE_DE_SKID_EN
        tbl.push_back(mk(1,0,1,0, 0,0,0,0,0,            0,1, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0, 0,20,0,0,8'h20,       0,1, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0, 0,21,0,0,8'h21,       1,1, 0,20,0,0,8'h20, 0));
        tbl.push_back(mk(0,1,0,0, 0,22,0,0,8'h22,       1,0, 0,20,0,0,8'h20, 1));
        tbl.push_back(mk(0,1,1,0, 0,22,0,0,8'h22,       1,0, 0,20,0,0,8'h20, 2));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,            1,1, 0,21,0,0,8'h21, 2));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,            0,1, 0,21,0,0,0, 2));
        tbl.push_back(mk(0,1,0,0, 0,30,0,0,8'h30,       0,1, 0,21,0,0,0, 2));
        tbl.push_back(mk(0,1,0,0, 0,31,0,0,8'h31,       1,1, 0,30,0,0,8'h30, 2));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0,            1,0, 0,30,0,0,8'h30, 3));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,            0,1, 0,30,0,0,0, 3));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,            0,1, 0,30,0,0,0, 3));
`else
        tbl.push_back(mk(1,1,1,0, 1,15,7,1,8'h5A,           0,1, 0,0,0,0,0, 0));
        tbl.push_back(mk(1,1,1,0, 1,15,7,1,8'h5A,           0,1, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,                0,1, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,1,0, 32'h100,15,1,2,8'h11,     0,1, 0,0,0,0,0, 0));
        tbl.push_back(mk(0,1,1,0, 32'h101,16,2,3,8'h12,     1,1, 32'h100,15,1,2,8'h11, 0));
        tbl.push_back(mk(0,1,1,0, 32'h102,17,3,4,8'h13,     1,1, 32'h101,16,2,3,8'h12, 0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,                1,1, 32'h102,17,3,4,8'h13, 0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,                0,1, 32'h102,17,3,4,0, 0));
        tbl.push_back(mk(0,1,1,0, 32'h200,30,7,5,8'h21,     0,1, 32'h102,17,3,4,0, 0));
        tbl.push_back(mk(0,1,0,0, 32'h201,31,9,6,8'h22,     1,0, 32'h200,30,7,5,8'h21, 0));
        tbl.push_back(mk(0,1,0,0, 32'h201,31,9,6,8'h22,     1,0, 32'h200,30,7,5,8'h21, 1));
        tbl.push_back(mk(0,1,0,0, 32'h201,31,9,6,8'h22,     1,0, 32'h200,30,7,5,8'h21, 2));
        tbl.push_back(mk(0,1,0,0, 32'h201,31,9,6,8'h22,     1,0, 32'h200,30,7,5,8'h21, 3));
        tbl.push_back(mk(0,1,1,0, 32'h201,31,9,6,8'h22,     1,1, 32'h200,30,7,5,8'h21, 4));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,                1,1, 32'h201,31,9,6,8'h22, 4));
        tbl.push_back(mk(0,1,0,0, 32'h300,40,41,3,8'h33,    0,1, 32'h201,31,9,6,0, 4));
        tbl.push_back(mk(0,1,0,1, 32'h400,50,51,7,8'h44,    1,0, 32'h300,40,41,3,8'h33, 4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,                0,1, 32'h300,40,41,3,0, 4));
        tbl.push_back(mk(0,1,1,0, 32'h500,60,61,8,8'h55,    0,1, 32'h300,40,41,3,0, 4));
        tbl.push_back(mk(0,1,1,1, 32'h600,70,71,9,8'h66,    1,1, 32'h500,60,61,8,8'h55, 4));
        tbl.push_back(mk(0,0,1,0, 0,0,0,0,0,                0,1, 32'h500,60,61,8,0, 4));
        tbl.push_back(mk(0,1,1,0, 32'h700,80,81,10,8'h77,   0,1, 32'h500,60,61,8,0, 4));
`endif

        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        advance();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vd, tbl[i].re, tbl[i].fl,
                  tbl[i].imm, tbl[i].rd1, tbl[i].rd2, tbl[i].wa3, tbl[i].ctrl);
            chk($sformatf("row%0d.valid_e", i), valid_e, tbl[i].e_ve);
            chk($sformatf("row%0d.ready_d", i), ready_d, tbl[i].e_rdy);
            chk($sformatf("row%0d.immExtE", i), immExtE, tbl[i].e_imm);
            chk($sformatf("row%0d.RD1E", i), RD1E, tbl[i].e_rd1);
            chk($sformatf("row%0d.RD2E", i), RD2E, tbl[i].e_rd2);
            chk($sformatf("row%0d.WA3E", i), WA3E, tbl[i].e_wa3);
            chk($sformatf("row%0d.ctrlE", i), ctrlE, tbl[i].e_ctrl);
            chk($sformatf("row%0d.stall_cnt", i), stall_cnt, tbl[i].e_cnt);
            advance();
        end

        // Saturation: one held instruction, 20 stall cycles, narrow counter must stick at 15.
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 1, 1, 0, 32'h900, 90, 91, 4'hB, 8'h99);
        advance();
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("sat%0d.stall_cnt", k), stall_cnt, k);
            chk($sformatf("sat%0d.stall_cnt_small", k), stall_cnt_s, (k > 15) ? 15 : k);
            chk($sformatf("sat%0d.RD1E", k), RD1E, 90);
            chk($sformatf("sat%0d.ready_d", k), ready_d, 1'b0);
            advance();
        end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("sat_end.stall_cnt", stall_cnt, 20);
        chk("sat_end.stall_cnt_small", stall_cnt_s, 15);
        chk("sat_end.valid_e", valid_e, 1'b1);
        advance();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("sat_drain.valid_e", valid_e, 1'b0);
        chk("sat_drain.ctrlE", ctrlE, 8'h00);
        chk("sat_drain.stall_cnt_small", stall_cnt_s, 15);
        advance();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) == 0),
                  $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            check_model();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
